// File: rtl/icache_ctrl.sv
// -----------------------------------------------------------------------------
// icache_ctrl
//   Direct-mapped, read-only instruction cache that sits between the CPU fetch
//   port and a block-wide instruction memory. A hit returns the addressed word
//   combinationally in the same cycle. A miss stalls the CPU while a whole line
//   is fetched (MEM_FETCH) and then installed (UPDATE).
//
// Ports
//   CLK           system clock, all state updates on posedge
//   RESET         asynchronous active-low reset (clears valid bits, FSM->IDLE)
//   ADDRESS       instruction byte address, bits [1:0] ignored
//   READ          CPU fetch request
//   INSTRUCTION   fetched word on a hit, zero otherwise
//   BUSYWAIT      stall to the CPU
//   MEM_READ      line read request to instruction memory
//   MEM_ADDRESS   line address {tag,index}
//   MEM_READDATA  returned line, word0 in the low 32 bits
//   MEM_BUSYWAIT  memory busy; data is valid in a MEM_READ cycle where it is low
// -----------------------------------------------------------------------------
module icache_ctrl #(
  parameter  int NUM_BLOCKS      = 8,
  parameter  int WORDS_PER_BLOCK = 4,
  parameter  int ADDR_WIDTH      = 10,
  localparam int IDX_W           = $clog2(NUM_BLOCKS),
  localparam int WSEL_W          = $clog2(WORDS_PER_BLOCK),
  localparam int OFF_W           = WSEL_W + 2,
  localparam int TAG_W           = ADDR_WIDTH - OFF_W - IDX_W,
  localparam int LINE_W          = WORDS_PER_BLOCK * 32
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [ADDR_WIDTH-1:0]    ADDRESS,
  input  logic                     READ,
  output logic [31:0]              INSTRUCTION,
  output logic                     BUSYWAIT,
  output logic                     MEM_READ,
  output logic [TAG_W+IDX_W-1:0]   MEM_ADDRESS,
  input  logic [LINE_W-1:0]        MEM_READDATA,
  input  logic                     MEM_BUSYWAIT
);

  typedef enum logic [1:0] {
    IDLE,
    MEM_FETCH,
    UPDATE
  } state_e;

  state_e state_q, state_d;

  logic [NUM_BLOCKS-1:0] valid_q;
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [LINE_W-1:0]     data_q [NUM_BLOCKS];
  logic [LINE_W-1:0]     fill_q;

  // Address split. The CPU holds ADDRESS for the whole miss, so these same
  // fields also address the line being installed.
  logic [TAG_W-1:0]  addr_tag;
  logic [IDX_W-1:0]  addr_index;
  logic [WSEL_W-1:0] addr_word;
  logic              unused_byte_bits;

  assign addr_tag         = ADDRESS[ADDR_WIDTH-1 -: TAG_W];
  assign addr_index       = ADDRESS[OFF_W +: IDX_W];
  assign addr_word        = ADDRESS[2 +: WSEL_W];
  assign unused_byte_bits = ^ADDRESS[1:0];

  logic hit;
  assign hit = READ & valid_q[addr_index] & (tag_q[addr_index] == addr_tag);

  assign INSTRUCTION = hit ? data_q[addr_index][{addr_word, 5'b0} +: 32] : 32'h0;
  assign MEM_ADDRESS = {addr_tag, addr_index};

  logic busy_raw;
  logic mem_read_raw;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    busy_raw     = 1'b0;
    mem_read_raw = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (READ && !hit) begin
          busy_raw = 1'b1;
          state_d  = MEM_FETCH;
        end
      end
      MEM_FETCH: begin
        busy_raw     = 1'b1;
        mem_read_raw = 1'b1;
        if (!MEM_BUSYWAIT) state_d = UPDATE;
      end
      UPDATE: begin
        busy_raw = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // While RESET is low the stall and the memory request must already be gone,
  // even though READ may still be high with every line now invalid.
  assign BUSYWAIT = RESET & busy_raw;
  assign MEM_READ = RESET & mem_read_raw;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == UPDATE) valid_q[addr_index] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays and the fill register are deliberately not reset;
  // cleared valid bits make their contents irrelevant, and leaving them out of
  // the reset lets them map onto plain storage.
  always_ff @(posedge CLK) begin
    if (state_q == MEM_FETCH && !MEM_BUSYWAIT) fill_q <= MEM_READDATA;
    if (state_q == UPDATE) begin
      data_q[addr_index] <= fill_q;
      tag_q[addr_index]  <= addr_tag;
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_icache_ctrl
//   Directed bench for icache_ctrl. A reference cache (valid/tag/line arrays)
//   and a memory image live in the bench; every access is classified as hit or
//   miss from that reference, and the expected per-cycle outputs follow from
//   the documented stall timeline (detect + N fetch cycles + update). Literal
//   expectations pin the reference model to known words and line addresses.
// -----------------------------------------------------------------------------
module tb_icache_ctrl;

  logic         CLK;
  logic         RESET;
  logic [9:0]   ADDRESS;
  logic         READ;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  icache_ctrl dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ADDRESS      (ADDRESS),
    .READ         (READ),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference cache contents.
  bit           m_valid [8];
  logic [2:0]   m_tag   [8];
  logic [127:0] m_data  [8];

  logic [5:0]   last_maddr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string name, input logic exp_busy,
                               input logic exp_mrd, input logic [31:0] exp_instr);
    check({name, ".busywait"}, 32'(BUSYWAIT), 32'(exp_busy));
    check({name, ".mem_read"}, 32'(MEM_READ), 32'(exp_mrd));
    check({name, ".instr"}, INSTRUCTION, exp_instr);
  endtask

  // Memory image: word w of line b holds (b << 8) | (w + 1).
  function automatic logic [127:0] mem_block(input logic [5:0] b);
    logic [127:0] blk;
    for (int w = 0; w < 4; w++)
      blk[w*32 +: 32] = ({26'd0, b} << 8) | 32'(w + 1);
    return blk;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One CPU fetch. Called 1 time unit after a posedge; returns likewise.
  // A miss must show: detect cycle, lat+1 fetch cycles, one update cycle,
  // then the hit cycle returning the word from the freshly installed line.
  task automatic access(input logic [9:0] a, input int lat);
    logic [2:0] idx, tg;
    logic [1:0] off;
    logic [5:0] blk;
    bit         hit;
    idx = a[6:4];
    tg  = a[9:7];
    off = a[3:2];
    blk = a[9:4];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    ADDRESS      = a;
    READ         = 1'b1;
    MEM_BUSYWAIT = 1'b1;
    MEM_READDATA = rand128();
    if (!hit) begin
      @(negedge CLK);
      check_outputs("miss_detect", 1'b1, 1'b0, 32'h0);
      for (int k = 1; k <= lat + 1; k++) begin
        @(posedge CLK); #1;
        MEM_BUSYWAIT = (k <= lat);
        MEM_READDATA = (k == lat + 1) ? mem_block(blk) : rand128();
        @(negedge CLK);
        check_outputs("fetch", 1'b1, 1'b1, 32'h0);
        check("fetch.mem_address", 32'(MEM_ADDRESS), 32'(blk));
        last_maddr = MEM_ADDRESS;
      end
      @(posedge CLK); #1;
      MEM_BUSYWAIT = 1'b1;
      MEM_READDATA = rand128();
      @(negedge CLK);
      check_outputs("update", 1'b1, 1'b0, 32'h0);
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_data[idx]  = mem_block(blk);
      @(posedge CLK); #1;
    end
    @(negedge CLK);
    check_outputs(hit ? "hit" : "post_fill_hit", 1'b0, 1'b0, m_data[idx][off*32 +: 32]);
    @(posedge CLK); #1;
  endtask

  // Single-cycle fetch expected to hit with a hand-computed word.
  task automatic lit(input logic [9:0] a, input logic [31:0] exp);
    ADDRESS = a;
    READ    = 1'b1;
    @(negedge CLK);
    check_outputs("literal_hit", 1'b0, 1'b0, exp);
    @(posedge CLK); #1;
  endtask

  // READ=0 cycle: no lookup, no stall, no memory traffic.
  task automatic no_read(input logic [9:0] a);
    ADDRESS      = a;
    READ         = 1'b0;
    MEM_BUSYWAIT = 1'b0;
    @(negedge CLK);
    check_outputs("read_low", 1'b0, 1'b0, 32'h0);
    @(posedge CLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    last_maddr   = '0;
    RESET        = 1'b0;
    READ         = 1'b1;
    ADDRESS      = 10'h000;
    MEM_BUSYWAIT = 1'b1;
    MEM_READDATA = '0;

    // Reset state, including READ=1 while held in reset.
    #3;
    check_outputs("reset", 1'b0, 1'b0, 32'h0);
    @(posedge CLK); #1;
    READ = 1'b0;
    @(negedge CLK);
    check_outputs("reset_idle", 1'b0, 1'b0, 32'h0);
    @(posedge CLK); #1;
    RESET = 1'b1;

    // Cold miss with 4 busy cycles, then sequential hits.
    access(10'h000, 4);
    check("cold.mem_address", 32'(last_maddr), 32'h00);
    lit(10'h000, 32'h0000_0001);
    lit(10'h004, 32'h0000_0002);
    lit(10'h008, 32'h0000_0003);
    lit(10'h00C, 32'h0000_0004);

    // Conflict miss at index 0, then the original line misses again.
    access(10'h080, 2);
    check("conflict.mem_address", 32'(last_maddr), 32'h08);
    lit(10'h084, 32'h0000_0802);
    access(10'h000, 1);
    check("refetch.mem_address", 32'(last_maddr), 32'h00);

    // Different index with a 1-cycle fetch leaves index 0 intact.
    access(10'h010, 0);
    check("index1.mem_address", 32'(last_maddr), 32'h01);
    lit(10'h01C, 32'h0000_0104);
    access(10'h000, 3);
    lit(10'h008, 32'h0000_0003);

    // READ=0: nothing happens, and an uncached line is still a miss afterwards.
    no_read(10'h000);
    no_read(10'h300);
    no_read(10'h3FC);
    no_read(10'h154);
    access(10'h300, 1);
    check("after_idle.mem_address", 32'(last_maddr), 32'h30);
    lit(10'h308, 32'h0000_3003);

    // Reset in the middle of a fetch; late memory data must be ignored.
    ADDRESS      = 10'h020;
    READ         = 1'b1;
    MEM_BUSYWAIT = 1'b1;
    @(negedge CLK);
    check_outputs("rst_mid.detect", 1'b1, 1'b0, 32'h0);
    @(posedge CLK); #1;
    @(negedge CLK);
    check_outputs("rst_mid.fetch", 1'b1, 1'b1, 32'h0);
    #1;
    RESET = 1'b0;
    #1;
    check_outputs("rst_mid.async", 1'b0, 1'b0, 32'h0);
    MEM_BUSYWAIT = 1'b0;
    MEM_READDATA = mem_block(6'h02);
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    check_outputs("rst_mid.held", 1'b0, 1'b0, 32'h0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    access(10'h020, 2);
    check("rst_refetch.mem_address", 32'(last_maddr), 32'h02);
    lit(10'h024, 32'h0000_0202);
    access(10'h000, 0);
    check("rst_cleared.mem_address", 32'(last_maddr), 32'h00);
    lit(10'h00C, 32'h0000_0004);

    READ = 1'b0;
    @(posedge CLK); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Direct-mapped, read-only instruction cache between the CPU's PC/INSTRUCTION port and the block-wide instruction memory.
- The CPU presents PC[9:0] and READ.
  - On a hit, the addressed 32-bit instruction is returned in the same cycle.
  - On a miss, BUSYWAIT stalls the CPU while a 128-bit block is fetched and installed.
- The CPU must hold PC and must not advance while BUSYWAIT=1.

Parameters:
- NUM_BLOCKS, 8, number of cache lines. Index width = log2(NUM_BLOCKS) = 3.
- WORDS_PER_BLOCK, 4, 32-bit instruction words per line. Line = 128 bits.
- ADDR_WIDTH, 10, byte address width taken from PC. Tag width = ADDR_WIDTH-4-log2(NUM_BLOCKS) = 3.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- RESET  input  1  asynchronous, active-low reset. Asserting 0 clears state immediately.
- ADDRESS  input  10  instruction byte address (PC[9:0]); bits [1:0] ignored.
- READ  input  1  CPU fetch request.
- INSTRUCTION  output  32  fetched instruction word.
- BUSYWAIT  output  1  stall to CPU.
- MEM_READ  output  1  block read request to instruction memory.
- MEM_ADDRESS  output  6  block address {tag,index}.
- MEM_READDATA  input  128  returned block; word0 = bits [31:0], word3 = bits [127:96].
- MEM_BUSYWAIT  input  1  memory busy; data valid in the cycle it is low while MEM_READ=1.

Behaviour:
- Address split:
  - tag = ADDRESS[9:7]
  - index = ADDRESS[6:4]
  - word offset = ADDRESS[3:2]
- Storage per line: valid bit, 3-bit tag, 128-bit data.
- hit = READ & valid[index] & (tag_array[index]==tag). Evaluated combinationally.
- INSTRUCTION:
  - On hit: data[index] word selected by offset.
  - Otherwise: 32'h0.
- FSM states: IDLE, MEM_FETCH, UPDATE.
  - IDLE:
    - BUSYWAIT = READ & ~hit.
    - MEM_READ = 0.
    - If READ & ~hit, go to MEM_FETCH next edge. Else stay.
  - MEM_FETCH:
    - MEM_READ = 1; MEM_ADDRESS = {tag,index} of the stalled ADDRESS; BUSYWAIT = 1.
    - While MEM_BUSYWAIT=1, stay.
    - On the edge where MEM_BUSYWAIT=0, latch MEM_READDATA into a fill register and go to UPDATE.
  - UPDATE:
    - BUSYWAIT = 1, MEM_READ = 0.
    - On the edge: data[index] <= fill register, tag_array[index] <= tag, valid[index] <= 1; go to IDLE.
- Miss latency:
  - BUSYWAIT rises in the miss cycle.
  - It is held for 1 (IDLE detect) + N (MEM_FETCH cycles incl. completion) + 1 (UPDATE) cycles.
  - The following IDLE cycle hits with BUSYWAIT=0.
- Hit latency: 0 cycles, no stall. Back-to-back hits are sustained every cycle.
- Replacement: conflicting tag at the same index overwrites the line. No write-back; the cache is read-only.
- READ=0: no lookup, BUSYWAIT=0, INSTRUCTION=0, no state change.
- ADDRESS changes during MEM_FETCH/UPDATE are illegal (CPU is stalled). MEM_ADDRESS comes from ADDRESS as held.
- Reset (RESET=0, asynchronous):
  - All valid bits cleared; FSM to IDLE.
  - MEM_READ=0, BUSYWAIT=0 (INSTRUCTION=0 since no hit).
  - Tag/data arrays are not cleared.
- Reset mid-miss: the fetch is abandoned and any late MEM_READDATA is ignored. After release, the same ADDRESS misses again and restarts the fetch.
- MEM_BUSYWAIT=0 on the first MEM_FETCH cycle is legal: 1-cycle fetch.

Test Plan:
- Cold miss, then hit:
  - Stimulus: RESET pulse; READ=1, ADDRESS=0x000. Memory holds MEM_BUSYWAIT=1 for 4 cycles, then returns 128'h00000004_00000003_00000002_00000001.
  - Required: BUSYWAIT=1 immediately; MEM_READ=1 with MEM_ADDRESS=0; BUSYWAIT falls after UPDATE; INSTRUCTION=32'h00000001.
- Sequential hits:
  - Stimulus: after the fill, ADDRESS=0x004, 0x008, 0x00C on consecutive cycles.
  - Required: INSTRUCTION=2,3,4 each cycle; BUSYWAIT=0; MEM_READ=0 throughout.
- Conflict miss:
  - Stimulus: ADDRESS=0x080 (tag 1, index 0), then 0x000.
  - Required: a miss with MEM_ADDRESS=6'h08, the line is replaced, and ADDRESS 0x000 then misses again with MEM_ADDRESS=0.
- Different index:
  - Stimulus: fill ADDRESS=0x010 (index 1), then return to 0x000.
  - Required: 0x000 still hits, with no MEM_READ.
- Reset mid-fetch:
  - Stimulus: drive RESET=0 during MEM_FETCH.
  - Required: MEM_READ and BUSYWAIT drop asynchronously; after release, the same address misses and refetches.
- READ=0:
  - Stimulus: READ=0 with any ADDRESS.
  - Required: BUSYWAIT=0, INSTRUCTION=0, MEM_READ never asserted.
